ps2_host_fifo: RTL and testbench
================================

PS2_HOST_FIFO -- requirements
Module: ps2_host_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning RX FIFO entries (power of 2, 2..256).
REQ-002 SHALL have parameter FILTER_LEN, default 4, meaning clk cycles a synchronised PS/2 line must be stable before it is accepted.
REQ-003 SHALL have parameter INHIBIT_CYCLES, default 5000, meaning clk cycles ps2_clk is held low before a host transmit.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning maximum clk cycles between device clock falling edges inside a frame.
REQ-005 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports ps2_clk_i and ps2_data_i, input, 1 each, raw PS/2 line levels.
REQ-008 SHALL have ports ps2_clk_oe and ps2_data_oe, output, 1 each; 1 means drive the line low, 0 means release (open drain).
REQ-009 SHALL have port addr, input, 2, register select: 0 RXDATA, 1 STATUS, 2 TXDATA, 3 CTRL.
REQ-010 SHALL have ports wdata (input, 8), we (input, 1, one-cycle write strobe), re (input, 1, one-cycle read strobe), rdata (output, 8).
REQ-011 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-012 SHALL pass each PS/2 input through a 2-FF synchroniser and a FILTER_LEN stability filter; a device-clock event is a filtered 1->0 transition.
REQ-013 SHALL implement FSM states IDLE, RX_BITS, RX_PARITY, RX_STOP, TX_INHIBIT, TX_START, TX_BITS, TX_PARITY, TX_STOP, TX_ACK.
REQ-014 RX: in IDLE, event with data=0 -> RX_BITS; 8 data bits sampled LSB first on events; then parity, then stop.
REQ-015 Frame SHALL be accepted only if parity is odd over data+parity and stop=1; else STATUS.frame_err set, byte discarded.
REQ-016 Accepted byte SHALL be pushed into the FIFO the cycle after the stop-bit event; if FIFO full, byte dropped and STATUS.overflow set.
REQ-017 Simultaneous push and pop when full SHALL perform both; count unchanged, no overflow.
REQ-018 rdata SHALL be combinational on addr; read of RXDATA with re=1 pops; read when empty returns 0x00 with no state change.
REQ-019 STATUS bits: [0] rx_empty, [1] rx_full, [2] overflow, [3] frame_err, [4] tx_busy, [5] tx_nack, [6] timeout, [7] 0.
REQ-020 CTRL bits: [0] irq_en (R/W); writing 1 to [1] clears bits 2,3,5,6 of STATUS (self-clearing, reads 0); [2] flush FIFO (self-clearing).
REQ-021 Write to TXDATA in IDLE SHALL latch byte, set tx_busy, enter TX_INHIBIT with ps2_clk_oe=1 for INHIBIT_CYCLES.
REQ-022 Write to TXDATA when not IDLE SHALL be ignored and set tx_nack.
REQ-023 TX_START: ps2_data_oe=1, ps2_clk_oe=0; on each event shift next bit (data_oe = ~bit), 8 data LSB first, odd parity, then stop (release).
REQ-024 TX_ACK: event with data=0 -> IDLE, tx_busy cleared; data=1 -> IDLE, tx_nack set.
REQ-025 In any non-IDLE state except TX_INHIBIT, TIMEOUT_CYCLES without an event SHALL release both lines, set timeout, return to IDLE, clear tx_busy.
REQ-026 irq SHALL equal irq_en AND (NOT rx_empty OR overflow OR frame_err OR tx_nack OR timeout).
REQ-027 RX events arriving in TX states SHALL be treated as TX bit timing, never as RX frames.

Reset
REQ-028 On reset: FSM IDLE, FIFO empty, all STATUS sticky bits 0, irq_en 0, ps2_clk_oe=0, ps2_data_oe=0, irq=0, filter/timers cleared.
REQ-029 Reset mid-frame (RX or TX) SHALL abandon the frame with no FIFO push and lines released the following cycle.

Structure
REQ-030 Register addresses, STATUS/CTRL bit indices and FSM state encoding SHALL reside in shared package ps2_pkg.
REQ-031 RX FIFO SHALL be a separate sub-module ps2_rx_fifo (sync, parametrised depth, push/pop/flush, count, full/empty).

Verification
REQ-032 Device sends 0x1C with correct parity -> one FIFO entry, RXDATA read returns 0x1C, rx_empty returns to 1.
REQ-033 Device sends 0xF0 with bad parity -> FIFO empty, frame_err=1, irq=1 when irq_en=1; CTRL write 0x02 clears it.
REQ-034 17 frames with FIFO_DEPTH=16, no reads -> rx_full=1, overflow=1, first 16 bytes read back in order.
REQ-035 Write 0xED to TXDATA, device model clocks and ACKs -> ps2_clk_oe high INHIBIT_CYCLES, bits 0xED LSB first, parity 1, tx_busy drops after ACK.
REQ-036 Device stops clocking after 4 RX bits -> after TIMEOUT_CYCLES timeout=1, FSM IDLE, next frame 0x29 received correctly.
REQ-037 Assert reset during TX_BITS -> both oe outputs 0 next cycle, tx_busy=0, FIFO empty.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host controller: register map, bit positions, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ps2_pkg;

    // Register map
    localparam logic [1:0] ADDR_RXDATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_TXDATA = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_EMPTY  = 0;
    localparam int ST_RX_FULL   = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_TX_BUSY   = 4;
    localparam int ST_TX_NACK   = 5;
    localparam int ST_TIMEOUT   = 6;

    // CTRL bit positions
    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_CLEAR   = 1;
    localparam int CTRL_FLUSH   = 2;

    typedef enum logic [3:0] {
        IDLE, RX_BITS, RX_PARITY, RX_STOP,
        TX_INHIBIT, TX_START, TX_BITS, TX_PARITY, TX_STOP, TX_ACK
    } ps2_state_t;

    // Parity bit that makes the total count of ones over data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous receive FIFO: push/pop/flush, occupancy count, full/empty flags.
// Latency: a pushed entry is visible at pop_dat the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module ps2_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/ps2_host_fifo.sv
// PS/2 host: filtered line sampling, RX frame decode into FIFO, host-to-device TX, register file.
// Latency: accepted byte lands in the FIFO two cycles after the stop-bit clock event is seen.
// Backpressure: FIFO full drops the byte (overflow); TXDATA writes while busy are rejected (tx_nack).
module ps2_host_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int FILTER_LEN     = 4,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    input  logic       re,
    output logic [7:0] rdata,
    output logic       irq
);
    localparam int FCW  = $clog2(FILTER_LEN) + 1;
    localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;

    // Index 0 = clock line, index 1 = data line.
    logic [1:0]     sync1, sync2, filt;
    logic [FCW-1:0] fcnt [2];
    logic           clk_prev;
    logic           ev;
    logic           line_data;

    ps2_state_t     state;
    logic [3:0]     bit_idx;
    logic [7:0]     shreg, tx_byte;
    logic           par;
    logic [TW-1:0]  timer;
    logic           push_req;
    logic           overflow, frame_err, tx_busy, tx_nack, timeout, irq_en;

    logic [7:0]     rx_dat;
    logic [$clog2(FIFO_DEPTH):0] rx_count;
    logic           rx_full, rx_empty, rd_pop, flush, ctrl_wr, tx_wr;
    logic [7:0]     status;

    assign ctrl_wr = we && (addr == ADDR_CTRL);
    assign tx_wr   = we && (addr == ADDR_TXDATA);
    assign flush   = ctrl_wr && wdata[CTRL_FLUSH];
    assign rd_pop  = re && (addr == ADDR_RXDATA) && !rx_empty;

    // Synchroniser plus stability filter: a new level must persist FILTER_LEN cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            filt     <= 2'b11;
            fcnt[0]  <= '0;
            fcnt[1]  <= '0;
            clk_prev <= 1'b1;
        end else begin
            sync1    <= {ps2_data_i, ps2_clk_i};
            sync2    <= sync1;
            clk_prev <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign ev        = clk_prev && !filt[0];
    assign line_data = filt[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_idx     <= '0;
            shreg       <= '0;
            tx_byte     <= '0;
            par         <= 1'b0;
            timer       <= '0;
            push_req    <= 1'b0;
            overflow    <= 1'b0;
            frame_err   <= 1'b0;
            tx_busy     <= 1'b0;
            tx_nack     <= 1'b0;
            timeout     <= 1'b0;
            irq_en      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            push_req <= 1'b0;
            // Clear first so that an event setting a flag in the same cycle is not lost.
            if (ctrl_wr) begin
                irq_en <= wdata[CTRL_IRQ_EN];
                if (wdata[CTRL_CLEAR]) begin
                    overflow  <= 1'b0;
                    frame_err <= 1'b0;
                    tx_nack   <= 1'b0;
                    timeout   <= 1'b0;
                end
            end
            if (push_req && rx_full && !rd_pop) overflow <= 1'b1;

            if (state == IDLE) begin
                if (tx_wr) begin
                    tx_byte    <= wdata;
                    tx_busy    <= 1'b1;
                    ps2_clk_oe <= 1'b1;
                    timer      <= '0;
                    state      <= TX_INHIBIT;
                end else if (ev && !line_data) begin
                    bit_idx <= '0;
                    timer   <= '0;
                    state   <= RX_BITS;
                end
            end else begin
                if (tx_wr) tx_nack <= 1'b1;
                if (state != TX_INHIBIT && !ev && timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    state       <= IDLE;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    timeout     <= 1'b1;
                    tx_busy     <= 1'b0;
                end else begin
                    // Our own clock pull-down during inhibit produces an event; ignore it.
                    timer <= (ev && state != TX_INHIBIT) ? '0 : timer + 1'b1;
                    case (state)
                        TX_INHIBIT: if (timer == TW'(INHIBIT_CYCLES - 1)) begin
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b1;
                            timer       <= '0;
                            state       <= TX_START;
                        end
                        RX_BITS: if (ev) begin
                            shreg   <= {line_data, shreg[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == 4'd7) state <= RX_PARITY;
                        end
                        RX_PARITY: if (ev) begin
                            par   <= line_data;
                            state <= RX_STOP;
                        end
                        RX_STOP: if (ev) begin
                            if ((^{shreg, par}) && line_data) push_req  <= 1'b1;
                            else                               frame_err <= 1'b1;
                            state <= IDLE;
                        end
                        TX_START: if (ev) begin
                            ps2_data_oe <= ~tx_byte[0];
                            bit_idx     <= 4'd1;
                            state       <= TX_BITS;
                        end
                        TX_BITS: if (ev) begin
                            if (bit_idx == 4'd8) begin
                                ps2_data_oe <= ~odd_parity(tx_byte);
                                state       <= TX_PARITY;
                            end else begin
                                ps2_data_oe <= ~tx_byte[bit_idx[2:0]];
                                bit_idx     <= bit_idx + 1'b1;
                            end
                        end
                        TX_PARITY: if (ev) begin
                            ps2_data_oe <= 1'b0;
                            state       <= TX_STOP;
                        end
                        TX_STOP: if (ev) state <= TX_ACK;
                        TX_ACK: if (ev) begin
                            tx_busy <= 1'b0;
                            if (line_data) tx_nack <= 1'b1;
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    ps2_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_req),
        .push_dat (shreg),
        .pop      (rd_pop),
        .flush    (flush),
        .pop_dat  (rx_dat),
        .count    (rx_count),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    always_comb begin
        status               = '0;
        status[ST_RX_EMPTY]  = rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_OVERFLOW]  = overflow;
        status[ST_FRAME_ERR] = frame_err;
        status[ST_TX_BUSY]   = tx_busy;
        status[ST_TX_NACK]   = tx_nack;
        status[ST_TIMEOUT]   = timeout;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_RXDATA: rdata = rx_empty ? 8'h00 : rx_dat;
            ADDR_STATUS: rdata = status;
            ADDR_TXDATA: rdata = tx_byte;
            default:     rdata = {7'b0, irq_en};
        endcase
    end

    assign irq = irq_en && ((rx_count != '0) || overflow || frame_err || tx_nack || timeout);

endmodule

// File: tb/tb_ps2_host_fifo.sv
module tb_ps2_host_fifo;
    import ps2_pkg::*;

    localparam int DEPTH = 16;
    localparam int FLT   = 4;
    localparam int INH   = 60;
    localparam int TO    = 500;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic [1:0] addr = ADDR_STATUS;
    logic [7:0] wdata = 8'h00;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic       ps2_clk_i, ps2_data_i, clk_oe, data_oe, irq;
    logic [7:0] rdata;

    // Open-drain wires: low if either side pulls low.
    assign ps2_clk_i  = dev_clk & ~clk_oe;
    assign ps2_data_i = dev_dat & ~data_oe;

    always #5 clk = ~clk;

    ps2_host_fifo #(
        .FIFO_DEPTH(DEPTH), .FILTER_LEN(FLT),
        .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe),
        .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .irq(irq)
    );

    // Behavioural model: byte queue plus sticky flags.
    logic [7:0] q[$];
    bit m_ovf, m_ferr, m_nack, m_to, m_busy, m_irq_en;
    bit chk_en = 1'b0;
    int n_chk = 0;
    int n_err = 0;

    function automatic logic [7:0] m_status();
        return {1'b0, m_to, m_nack, m_busy, m_ferr, m_ovf,
                q.size() == DEPTH, q.size() == 0};
    endfunction

    function automatic logic m_irq();
        return m_irq_en & ((q.size() != 0) | m_ovf | m_ferr | m_nack | m_to);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0; addr = ADDR_STATUS;
    endtask

    task automatic rd(output logic [7:0] v);
        logic [7:0] e;
        @(negedge clk);
        addr = ADDR_RXDATA; re = 1'b1;
        #1 v = rdata;
        e = (q.size() != 0) ? q.pop_front() : 8'h00;
        chk("rxdata_vs_model", {24'h0, v}, {24'h0, e});
        @(negedge clk);
        re = 1'b0; addr = ADDR_STATUS;
        #1;
    endtask

    // Device-to-host frame; nbits < 11 truncates the frame.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_dat = f[i];
            cyc(10); dev_clk = 1'b0;
            cyc(20); dev_clk = 1'b1;
        end
        cyc(10); dev_dat = 1'b1; cyc(10);
        if (nbits == 11) begin
            if (bad_par)              m_ferr = 1'b1;
            else if (q.size() < DEPTH) q.push_back(b);
            else                       m_ovf = 1'b1;
        end
    endtask

    // Device side of host-to-device transfer: clocks, samples on rising edges, ACKs.
    task automatic dev_tx(input bit nack, output logic [7:0] got, output bit gp, output bit gs);
        got = '0; gp = 1'b0; gs = 1'b0;
        cyc(10);
        chk("tx_start_data_oe", {31'h0, data_oe}, 32'd1);
        for (int k = 1; k <= 12; k++) begin
            if (k == 12) dev_dat = nack;
            cyc(10); dev_clk = 1'b0;
            cyc(20); dev_clk = 1'b1;
            if (k <= 8)  got[k-1] = ps2_data_i;
            if (k == 9)  gp = ps2_data_i;
            if (k == 10) gs = ps2_data_i;
        end
        cyc(10); dev_dat = 1'b1;
    endtask

    // Continuous compare against the model while the bus is quiet.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (chk_en && !reset && addr == ADDR_STATUS && !we && !re) begin
                chk("status_vs_model", {24'h0, rdata}, {24'h0, m_status()});
                chk("irq_vs_model", {31'h0, irq}, {31'h0, m_irq()});
                chk("lines_released", {30'h0, clk_oe, data_oe}, 32'd0);
            end
        end
    end

    initial begin
        #3_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        logic [7:0] v, got;
        bit gp, gs;
        int cnt;

        cyc(3); reset = 1'b0; #1;
        // Reset state
        chk("rst_status", {24'h0, rdata}, 32'h01);
        chk("rst_irq", {31'h0, irq}, 32'd0);
        chk("rst_oe", {30'h0, clk_oe, data_oe}, 32'd0);
        @(negedge clk); addr = ADDR_CTRL; #1 chk("rst_ctrl", {24'h0, rdata}, 32'h00);
        addr = ADDR_RXDATA; #1 chk("rst_rxdata", {24'h0, rdata}, 32'h00);
        addr = ADDR_STATUS;
        chk_en = 1'b1; cyc(5);

        // Good frame 0x1C
        chk_en = 1'b0;
        send_frame(8'h1C, 1'b0, 11);
        #1 chk("rx1c_status", {24'h0, rdata}, 32'h00);
        chk_en = 1'b1; cyc(5);
        rd(v);
        chk("rx1c_data", {24'h0, v}, 32'h1C);
        chk("rx1c_empty_again", {24'h0, rdata}, 32'h01);

        // Bad parity 0xF0 with irq enabled
        wr(ADDR_CTRL, 8'h01); m_irq_en = 1'b1;
        chk_en = 1'b0;
        send_frame(8'hF0, 1'b1, 11);
        #1 chk("ferr_status", {24'h0, rdata}, 32'h09);
        chk("ferr_irq", {31'h0, irq}, 32'd1);
        chk_en = 1'b1; cyc(5);
        wr(ADDR_CTRL, 8'h02);
        m_irq_en = 1'b0; m_ovf = 0; m_ferr = 0; m_nack = 0; m_to = 0;
        #1 chk("ferr_cleared", {24'h0, rdata}, 32'h01);
        chk("ferr_irq_off", {31'h0, irq}, 32'd0);
        cyc(5);

        // 17 frames into a 16-deep FIFO
        chk_en = 1'b0;
        for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 1'b0, 11);
        #1 chk("ovf_status", {24'h0, rdata}, 32'h06);
        chk_en = 1'b1; cyc(5);
        for (int i = 0; i < 16; i++) begin
            rd(v);
            chk("ovf_order", {24'h0, v}, 32'h10 + i);
        end
        rd(v);
        chk("empty_read_zero", {24'h0, v}, 32'h00);
        chk("empty_read_status", {24'h0, rdata}, 32'h05);
        wr(ADDR_CTRL, 8'h02); m_ovf = 0; m_ferr = 0; m_nack = 0; m_to = 0;
        cyc(5);

        // Host transmit 0xED
        chk_en = 1'b0;
        wr(ADDR_TXDATA, 8'hED); m_busy = 1'b1;
        cnt = 0;
        while (clk_oe && cnt < INH + 50) begin
            cnt++;
            @(negedge clk);
        end
        chk("inhibit_len", cnt, INH);
        dev_tx(1'b0, got, gp, gs);
        chk("tx_bits", {24'h0, got}, 32'hED);
        chk("tx_parity", {31'h0, gp}, 32'd1);
        chk("tx_stop", {31'h0, gs}, 32'd1);
        cyc(20); m_busy = 1'b0;
        #1 chk("tx_done_status", {24'h0, rdata}, 32'h01);
        chk_en = 1'b1; cyc(5);

        // Stalled frame then timeout, then a clean frame 0x29
        chk_en = 1'b0;
        send_frame(8'h33, 1'b0, 5);
        cyc(TO / 2);
        #1 chk("pre_timeout_status", {24'h0, rdata}, 32'h01);
        cyc(TO);
        m_to = 1'b1;
        #1 chk("timeout_status", {24'h0, rdata}, 32'h41);
        chk_en = 1'b1; cyc(5);
        chk_en = 1'b0;
        send_frame(8'h29, 1'b0, 11);
        chk_en = 1'b1; cyc(5);
        rd(v);
        chk("rx29_data", {24'h0, v}, 32'h29);
        wr(ADDR_CTRL, 8'h02); m_ovf = 0; m_ferr = 0; m_nack = 0; m_to = 0;
        cyc(5);

        // Reset during TX_BITS; a second TXDATA write while busy is refused
        chk_en = 1'b0;
        wr(ADDR_TXDATA, 8'h5A); m_busy = 1'b1;
        wr(ADDR_TXDATA, 8'h00); m_nack = 1'b1;
        #1 chk("busy_nack_status", {24'h0, rdata}, 32'h31);
        cnt = 0;
        while (clk_oe && cnt < INH + 50) begin
            cnt++;
            @(negedge clk);
        end
        cyc(10);
        for (int k = 0; k < 3; k++) begin
            cyc(10); dev_clk = 1'b0;
            cyc(20); dev_clk = 1'b1;
        end
        cyc(5);
        #1 chk("txbits_data_oe", {31'h0, data_oe}, 32'd1);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;
        chk("rst_mid_tx_oe", {30'h0, clk_oe, data_oe}, 32'd0);
        reset = 1'b0;
        q.delete();
        m_ovf = 0; m_ferr = 0; m_nack = 0; m_to = 0; m_busy = 0; m_irq_en = 0;
        #1 chk("rst_mid_tx_status", {24'h0, rdata}, 32'h01);
        chk_en = 1'b1; cyc(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
